// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and lane/extend helpers for the data memory
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? 4'b0001 << a : sz == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  // Stores replicate the low byte/half across all lanes; the enables pick the target.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    return sz == SZ_BYTE ? {4{d[7:0]}} : sz == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return sz == SZ_BYTE ? {{24{~uns & b[7]}}, b} : sz == SZ_HALF ? {{16{~uns & h[15]}}, h} : w;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? a[0] : a != 2'b00;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word array with four byte-lane write enables and an asynchronous read port
module dmem_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: byte/half/word data memory with a wait-state FSM that stalls the core.
// Define DMEM_MISALIGN_TRAP_EN to add the misalign output and suppress misaligned accesses.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);
  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("dmem_wait_ctrl: DATA_WIDTH must be 32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("dmem_wait_ctrl: WAIT_STATES must be 0..15");
  end
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx, we;
  logic [31:0] ram_q;
  logic req, mis, unused_hi;
  assign req = (mem_read | mem_write) & ~reset;
  assign unused_hi = ^addr[31:ADDR_WIDTH+2];
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = misaligned(size, addr[1:0]);
  assign misalign = done & mis;
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // Counter holds remaining WAIT cycles; a misaligned request skips WAIT entirely.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (req && WAIT_STATES > 0) begin
        state_nx = (mis || WS_M1 == 4'd0) ? DONE : WAIT;
        cnt_nx = WS_M1;
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        state_nx = cnt <= 4'd1 ? DONE : WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    stall = (state == IDLE && req && WAIT_STATES > 0) || state == WAIT;
    done = (state == IDLE && req && WAIT_STATES == 0) || state == DONE;
    we = done && mem_write && !mis ? lane_en(size, addr[1:0]) : 4'b0000;
    rdata = done && mem_read && !mem_write && !mis ? load_ext(ram_q, size, addr[1:0], unsigned_ld) : 32'd0;
  end
  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .we(we),
    .idx(addr[ADDR_WIDTH+1:2]),
    .wdata(lane_data(size, wdata)),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: scoreboard bench for a 2-wait-state and a zero-wait-state instance
module tb_dmem_wait_ctrl;
  import dmem_pkg::*;
  typedef struct {
    logic [31:0] rd;
    int          st;
    logic        mis;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst2, rd2, wr2, un2, stall2, done2;
  logic rst0, rd0, wr0, un0, stall0, done0;
  logic [31:0] ad2, wd2, q2, ad0, wd0, q0;
  logic [1:0] sz2, sz0;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis2, mis0;
`endif
  int n_cmp = 0, n_err = 0;
  int st2 = 0, st0 = 0;
  exp_t sb2[$], sb0[$];
  exp_t e2, e0;

  dmem_wait_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(rst2), .mem_read(rd2), .mem_write(wr2), .addr(ad2), .wdata(wd2),
    .size(sz2), .unsigned_ld(un2), .rdata(q2), .stall(stall2), .done(done2)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalign(mis2)
`endif
  );
  dmem_wait_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .mem_read(rd0), .mem_write(wr0), .addr(ad0), .wdata(wd0),
    .size(sz0), .unsigned_ld(un0), .rdata(q0), .stall(stall0), .done(done0)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalign(mis0)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic score(input string nm, input logic [31:0] q, input int st, input exp_t e);
    chk({nm, "_rdata"}, q, e.rd);
    chk({nm, "_stall_cycles"}, 32'(st), 32'(e.st));
  endtask

  always @(negedge clk) begin
    if (rst2) st2 = 0;
    else begin
      if (stall2) st2++;
      if (done2) begin
        if (sb2.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ws2_unexpected_done: got done=1 expected no access at %0t", $time);
        end else begin
          e2 = sb2.pop_front();
          score("ws2", q2, st2, e2);
`ifdef DMEM_MISALIGN_TRAP_EN
          chk("ws2_misalign", 32'(mis2), 32'(e2.mis));
`endif
        end
        st2 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst0) st0 = 0;
    else begin
      if (stall0) st0++;
      if (done0) begin
        if (sb0.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ws0_unexpected_done: got done=1 expected no access at %0t", $time);
        end else begin
          e0 = sb0.pop_front();
          score("ws0", q0, st0, e0);
`ifdef DMEM_MISALIGN_TRAP_EN
          chk("ws0_misalign", 32'(mis0), 32'(e0.mis));
`endif
        end
        st0 = 0;
      end
    end
  end

  // z selects the zero-wait instance; inputs are held until done, then dropped.
  task automatic acc(input bit z, input logic r, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] rx,
                     input int st, input logic m);
    int i = 0;
    if (z) begin
      sb0.push_back('{rx, st, m});
      rd0 = r; wr0 = w; sz0 = s; un0 = u; ad0 = a; wd0 = d;
    end else begin
      sb2.push_back('{rx, st, m});
      rd2 = r; wr2 = w; sz2 = s; un2 = u; ad2 = a; wd2 = d;
    end
    do begin
      @(negedge clk);
      i++;
    end while (!(z ? done0 : done2) && i < 20);
    if (!(z ? done0 : done2)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done within %0d", z ? "ws0" : "ws2", i, st + 1);
      if (z) sb0.delete(); else sb2.delete();
    end
    @(posedge clk);
    #1;
    if (z) begin rd0 = 1'b0; wr0 = 1'b0; end
    else begin rd2 = 1'b0; wr2 = 1'b0; end
  endtask

  task automatic abort2(input logic [31:0] a, input logic [31:0] d);
    rd2 = 1'b0; wr2 = 1'b1; sz2 = SZ_WORD; ad2 = a; wd2 = d;
    @(posedge clk);
    #1;
    chk("ws2_abort_in_wait_stall", 32'(stall2), 32'd1);
    rst2 = 1'b1;
    wr2 = 1'b0;
    #1;
    chk("ws2_abort_stall", 32'(stall2), 32'd0);
    chk("ws2_abort_done", 32'(done2), 32'd0);
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    chk("ws2_after_abort_stall", 32'(stall2), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    rst2 = 1'b1; rd2 = 1'b0; wr2 = 1'b0; un2 = 1'b0; ad2 = '0; wd2 = '0; sz2 = SZ_WORD;
    rst0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; un0 = 1'b0; ad0 = '0; wd0 = '0; sz0 = SZ_WORD;
    @(negedge clk);
    chk("ws2_reset_stall", 32'(stall2), 32'd0);
    chk("ws2_reset_done", 32'(done2), 32'd0);
    chk("ws2_reset_rdata", q2, 32'd0);
    chk("ws0_reset_stall", 32'(stall0), 32'd0);
    chk("ws0_reset_done", 32'(done0), 32'd0);
    chk("ws0_reset_rdata", q0, 32'd0);
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    rst0 = 1'b0;
    fork
      begin
        acc(0, 0, 1, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h0,        2, 0);
        acc(0, 1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'hDEADBEEF, 2, 0);
        acc(0, 0, 1, SZ_BYTE, 0, 32'h13,  32'h80,       32'h0,        2, 0);
        acc(0, 1, 0, SZ_BYTE, 0, 32'h13,  32'h0,        32'hFFFFFF80, 2, 0);
        acc(0, 1, 0, SZ_BYTE, 1, 32'h13,  32'h0,        32'h00000080, 2, 0);
        acc(0, 1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'h80ADBEEF, 2, 0);
        acc(0, 0, 1, SZ_HALF, 0, 32'h12,  32'h1234,     32'h0,        2, 0);
        acc(0, 1, 0, SZ_HALF, 0, 32'h12,  32'h0,        32'h00001234, 2, 0);
        acc(0, 1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'h1234BEEF, 2, 0);
        acc(0, 1, 0, SZ_HALF, 0, 32'h10,  32'h0,        32'hFFFFBEEF, 2, 0);
        acc(0, 1, 0, SZ_HALF, 1, 32'h10,  32'h0,        32'h0000BEEF, 2, 0);
        acc(0, 1, 0, SZ_BYTE, 0, 32'h11,  32'h0,        32'hFFFFFFBE, 2, 0);
        acc(0, 1, 0, 2'b11,   0, 32'h10,  32'h0,        32'h1234BEEF, 2, 0);
        acc(0, 0, 1, SZ_WORD, 0, 32'h400, 32'hA5A5A5A5, 32'h0,        2, 0);
        acc(0, 1, 0, SZ_WORD, 0, 32'h0,   32'h0,        32'hA5A5A5A5, 2, 0);
        acc(0, 0, 1, SZ_WORD, 0, 32'h20,  32'h11223344, 32'h0,        2, 0);
        abort2(32'h20, 32'h55);
        acc(0, 1, 0, SZ_WORD, 0, 32'h20,  32'h0,        32'h11223344, 2, 0);
        acc(0, 1, 1, SZ_WORD, 0, 32'h30,  32'h77,       32'h0,        2, 0);
        acc(0, 1, 0, SZ_WORD, 0, 32'h30,  32'h0,        32'h77,       2, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        acc(0, 1, 0, SZ_WORD, 0, 32'h02,  32'h0,        32'h0,        1, 1);
        acc(0, 0, 1, SZ_WORD, 0, 32'h02,  32'hFFFFFFFF, 32'h0,        1, 1);
        acc(0, 0, 1, SZ_HALF, 0, 32'h11,  32'hFFFF,     32'h0,        1, 1);
        acc(0, 1, 0, SZ_WORD, 0, 32'h0,   32'h0,        32'hA5A5A5A5, 2, 0);
        acc(0, 1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'h1234BEEF, 2, 0);
`else
        acc(0, 1, 0, SZ_HALF, 0, 32'h13,  32'h0,        32'h00001234, 2, 0);
        acc(0, 0, 1, SZ_WORD, 0, 32'h33,  32'h89ABCDEF, 32'h0,        2, 0);
        acc(0, 1, 0, SZ_WORD, 0, 32'h30,  32'h0,        32'h89ABCDEF, 2, 0);
`endif
      end
      begin
        acc(1, 0, 1, SZ_WORD, 0, 32'h8,   32'hCAFEF00D, 32'h0,        0, 0);
        acc(1, 1, 0, SZ_WORD, 0, 32'h8,   32'h0,        32'hCAFEF00D, 0, 0);
        acc(1, 0, 1, SZ_BYTE, 0, 32'h9,   32'h7F,       32'h0,        0, 0);
        acc(1, 1, 0, SZ_BYTE, 0, 32'h9,   32'h0,        32'h0000007F, 0, 0);
        acc(1, 1, 0, SZ_WORD, 0, 32'h8,   32'h0,        32'hCAFE7F0D, 0, 0);
        acc(1, 1, 0, SZ_HALF, 1, 32'hA,   32'h0,        32'h0000CAFE, 0, 0);
        acc(1, 1, 0, SZ_HALF, 0, 32'hA,   32'h0,        32'hFFFFCAFE, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        acc(1, 0, 1, SZ_WORD, 0, 32'h9,   32'h0,        32'h0,        0, 1);
        acc(1, 1, 0, SZ_WORD, 0, 32'h8,   32'h0,        32'hCAFE7F0D, 0, 0);
`endif
      end
    join
    repeat (3) @(posedge clk);
    chk("ws2_pending", 32'(sb2.size()), 32'd0);
    chk("ws0_pending", 32'(sb0.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
